// File: rtl/ripple_count_capture.sv
// ripple_count_capture
//
// Consumer of a free-running asynchronous ripple counter. The counter value is
// brought into the Clk domain through a three-stage sampling chain, and only
// values seen identically on two consecutive samples are trusted. This rejects
// the transient codes that appear while the counter ripples. Each accepted
// value is turned into an increment relative to the previous accepted value.
// The increment is added into a wide running total, and sticky flags report a
// threshold crossing and an accumulator overflow.
//
// Ports:
//   Clk        - system clock; all state updates on the rising edge
//   rst        - asynchronous, active-high reset of every register
//   cnt_in     - ripple counter output (asynchronous to Clk, may glitch)
//   src_clear  - clear that also drives the ripple counter (asynchronous)
//   clr        - synchronous clear of total, thresh_hit and ovf
//   cnt_stable - last accepted (filtered) counter value
//   total      - accumulated increment count
//   upd        - one-cycle pulse in the cycle after cnt_stable/total change
//   thresh_hit - sticky: total has reached THRESHOLD
//   ovf        - sticky: total wrapped past its maximum value

module ripple_count_capture #(
    parameter int                 CNT_W     = 4,
    parameter int                 TOTAL_W   = 16,
    parameter logic [TOTAL_W-1:0] THRESHOLD = 16'd100
) (
    input  logic               Clk,
    input  logic               rst,
    input  logic [CNT_W-1:0]   cnt_in,
    input  logic               src_clear,
    input  logic               clr,
    output logic [CNT_W-1:0]   cnt_stable,
    output logic [TOTAL_W-1:0] total,
    output logic               upd,
    output logic               thresh_hit,
    output logic               ovf
);

    logic [CNT_W-1:0]   s1, s2, s3;
    logic               c1, c2;
    logic               accept;
    logic [CNT_W-1:0]   delta;
    logic [TOTAL_W:0]   sum;

    // s1 may go metastable; s2 and s3 are two settled samples taken one cycle
    // apart. A value is trusted only when both agree, so a code that lasts for
    // a single sample never qualifies. The source clear holds acceptance off
    // and is synchronized separately.
    always_comb begin
        accept = (s2 == s3) && (s2 != cnt_stable) && !c2;
        // Modular subtraction makes a counter wrap (e.g. 15 -> 0) count as a
        // forward step. This holds as long as the counter moves less than a
        // full turn between acceptances.
        delta  = s2 - cnt_stable;
        // The extra top bit of the sum is the overflow carry. The total itself
        // keeps only the wrapped low bits.
        sum    = {1'b0, total} + {{(TOTAL_W + 1 - CNT_W){1'b0}}, delta};
    end

    // Sampling chain and source-clear synchronizer run every cycle. Neither
    // is touched by the synchronous clr.
    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
            c1 <= 1'b0;
            c2 <= 1'b0;
        end else begin
            s1 <= cnt_in;
            s2 <= s1;
            s3 <= s2;
            c1 <= src_clear;
            c2 <= c1;
        end
    end

    // Filtered value and update pulse. A source clear zeroes the tracked value
    // so counting restarts from 0 once the clear is released.
    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            cnt_stable <= '0;
            upd        <= 1'b0;
        end else begin
            upd <= 1'b0;
            if (c2) begin
                cnt_stable <= '0;
            end else if (accept) begin
                cnt_stable <= s2;
                upd        <= 1'b1;
            end
        end
    end

    // Accumulator and sticky flags. If clr arrives on the same edge as an
    // acceptance, the increment is discarded. The filtered value still
    // advances in the block above, so the next increment is measured from it.
    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            total      <= '0;
            thresh_hit <= 1'b0;
            ovf        <= 1'b0;
        end else if (clr) begin
            total      <= '0;
            thresh_hit <= 1'b0;
            ovf        <= 1'b0;
        end else if (accept) begin
            total <= sum[TOTAL_W-1:0];
            if (sum[TOTAL_W]) begin
                ovf <= 1'b1;
            end
            if (sum[TOTAL_W-1:0] >= THRESHOLD) begin
                thresh_hit <= 1'b1;
            end
        end
    end

endmodule

// File: doc/ripple_count_capture.md
Name: ripple_count_capture

Overview:
- Downstream consumer of the 4-bit asynchronous ripple counter output.
- Brings the free-running, glitch-prone ripple count into the system Clk domain and filters ripple transients.
- Converts successive count values into increments and accumulates them into a wide total register.
- Flags a programmable threshold crossing and accumulator overflow for control logic.

Parameters:
- CNT_W, 4, width of the ripple counter value being sampled.
- TOTAL_W, 16, width of the accumulated total.
- THRESHOLD, 16'd100, total value at or above which thresh_hit asserts (TOTAL_W bits).

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- cnt_in  input  CNT_W  ripple counter output; asynchronous to Clk, may glitch during ripple.
- src_clear  input  1  same clear that drives the ripple counter; asynchronous to Clk.
- clr  input  1  synchronous clear of total and sticky flags.
- cnt_stable  output  CNT_W  last accepted (filtered) counter value.
- total  output  TOTAL_W  accumulated increment count.
- upd  output  1  one-cycle pulse on the cycle cnt_stable/total take a new value.
- thresh_hit  output  1  sticky; total has reached THRESHOLD.
- ovf  output  1  sticky; total wrapped past 2^TOTAL_W-1.

Behaviour:
- Reset: rst=1 immediately forces every register to 0 (sync stages, cnt_stable, total, upd, thresh_hit, ovf), regardless of Clk.
- Sync chain: s1<=cnt_in, s2<=s1, s3<=s2 every edge. src_clear passes through its own 2-flop synchronizer (c1, c2).
- Accept condition: s2==s3 AND s2!=cnt_stable AND c2==0.
- On accept edge: cnt_stable<=s2; delta=(s2-cnt_stable) mod 2^CNT_W; total<=total+delta (mod 2^TOTAL_W); upd<=1. Otherwise upd<=0.
- Latency: a cnt_in value stable before edge E appears on cnt_stable/total at edge E+3; upd is high for the cycle after E+3.
- Glitch rejection: a value present for only one sampled edge never satisfies s2==s3 and is never accepted.
- Wrap: 15->0 yields delta 1; 14->1 yields delta 3.
- Rate constraint: the ripple counter must advance fewer than 2^CNT_W counts per 3 Clk cycles. Faster input aliases, and this is not detected.
- Overflow: if total+delta >= 2^TOTAL_W, total keeps the wrapped low bits and ovf<=1 (sticky).
- Threshold: thresh_hit<=1 on the same edge the new total becomes >= THRESHOLD; it stays high (sticky), including after an overflow wrap.
- src_clear (c2==1): cnt_stable<=0, no accumulation, upd<=0, total unchanged. After c2 falls, tracking resumes from 0.
- clr (when rst=0): total<=0, thresh_hit<=0, ovf<=0.
- clr coinciding with accept: cnt_stable still updates, upd pulses, delta is discarded (total=0).
- clr does not affect the sync chain or cnt_stable.
- Priority: rst > src_clear (for cnt_stable) > clr (for total/flags) > accept.

Test Plan:
- Reset: assert rst mid-cycle with total=37 -> all outputs 0 before the next Clk edge. Release, cnt_in=0 -> no upd.
- Stepping: cnt_in 0->1->2->3, each held 8 cycles -> 3 upd pulses, each 3 edges after the change; total=3, cnt_stable=3.
- Wrap and jump: cnt_stable=14, cnt_in=1 held -> total +3. From 15, cnt_in=0 -> total +1.
- Glitch: cnt_stable=7, cnt_in=4 for exactly 1 cycle then 8 -> single upd, cnt_stable=8, total +1.
- Threshold/overflow/clr: THRESHOLD=20, TOTAL_W=8.
  - Reach total=20 -> thresh_hit rises on that edge.
  - Drive total past 255 -> ovf=1, total wraps.
  - Pulse clr -> total=0, thresh_hit=0, ovf=0; cnt_stable unchanged.
- src_clear: cnt_stable=9, assert src_clear with cnt_in=0 -> cnt_stable=0, total unchanged, no upd. Release, cnt_in=3 -> total +3.
